i2c_write_engine: RTL
=====================

// Module: i2c_write_engine
// PURPOSE
//  Bit-level I2C master, write-only. Takes a 7-bit slave address and a byte
//  stream from the upstream message sequencer (valid/ready). Generates START,
//  address+W, data bytes, ACK checks and STOP on open-drain SCL/SDA.
//  Sits directly upstream of the GPIO tri-state pads; each *_oe output drives
//  its pad low when 1 and releases it (pulled high) when 0.
// PARAMETERS
//  CLK_DIV  125  clock cycles per quarter SCL period (50 MHz -> 100 kHz); must be >= 2
// PORTS
//  clock     in   1  system clock, all logic on posedge
//  reset_L   in   1  synchronous, active-low reset
//  start     in   1  begin transaction; sampled only in IDLE
//  addr      in   7  slave address, latched on accepted start
//  wr_data   in   8  data byte from sequencer
//  wr_last   in   1  wr_data is final byte of transaction
//  wr_valid  in   1  wr_data/wr_last valid
//  wr_ready  out  1  engine accepts byte this cycle (valid & ready = transfer)
//  sda_in    in   1  synchronized SDA pad level (used for ACK sampling)
//  scl_oe    out  1  1 = pull SCL low
//  sda_oe    out  1  1 = pull SDA low
//  busy      out  1  high from accepted start until done
//  done      out  1  one-cycle pulse when STOP completes
//  nack      out  1  sticky: slave NACKed; cleared on next accepted start
// BEHAVIOUR
//  Reset (reset_L=0 at posedge): state IDLE; scl_oe=sda_oe=0, busy=0,
//   wr_ready=0, done=0, nack=0; divider and bit counters cleared. Reset mid-
//   transaction releases both lines on the next cycle; no STOP is generated.
//  Timing: quarter counter counts 0..CLK_DIV-1; state work advances per quarter (q0..q3).
//  States:
//   IDLE : lines released. start=1 -> latch addr, nack<=0, busy<=1, -> START.
//          start while not IDLE is ignored.
//   START: q0-q1 SDA,SCL released; q2-q3 SDA low, SCL released; -> ADDR.
//   ADDR/DATA: 8 bits MSB first; shift reg = {addr,1'b0} or latched byte.
//          Per bit: q0 SCL low + drive SDA (sda_oe = ~bit); q1 SCL low;
//          q2-q3 SCL released. After bit 7 -> ACK.
//   ACK  : q0-q1 SCL low, SDA released; q2-q3 SCL released; sda_in sampled
//          on last cycle of q2. sda_in=1 -> nack<=1, -> STOP.
//          ACK ok: after ADDR or non-last byte -> LOAD; after last byte -> STOP.
//   LOAD : SCL held low, SDA released, wr_ready=1. valid&ready -> latch
//          wr_data and wr_last, -> DATA next cycle. wr_valid=0 -> wait
//          indefinitely with SCL low (master stretch). Minimum 1 cycle.
//   STOP : q0 SCL low SDA low; q1 SCL released SDA low; q2-q3 both released;
//          then done=1 for one cycle, busy<=0, -> IDLE.
//  wr_ready asserted only in LOAD; never during ADDR-NACK or STOP.
//  Frame length: START 4q + 9q*4 per byte (incl. address) + STOP 4q,
//   plus LOAD cycles; divider restarts at 0 on each state entry.
//  wr_last held only at transfer; bytes after NACK never requested.
// TESTING (CLK_DIV=4 for sim; slave model ACKs unless stated)
//  1 reset_L=0 for 2 cycles mid-DATA -> next cycle scl_oe=sda_oe=busy=wr_ready=done=nack=0;
//    subsequent start works normally.
//  2 addr=0x27, one byte 0x48 last=1, valid held high -> bus shows START, 0x4E,
//    ACK, 0x48, ACK, STOP; done pulses once at 320+1 cycles after start; nack=0.
//  3 addr=0x27, slave NACKs address -> nack=1, STOP issued, done pulses,
//    wr_ready never asserted; nack clears on next start.
//  4 "hello" (0x68,0x65,0x6C,0x6C,0x6F, last on 0x6F), wr_valid withheld 10
//    cycles before byte 3 -> scl_oe=1 throughout wait; bytes appear in order.
//  5 data NACK on byte 2 of 5 -> STOP after that ACK, nack=1, bytes 3-5 not requested.
//  6 start pulsed while busy -> ignored; addr change mid-frame has no effect.

Source files
------------

// File: rtl/i2c_write_engine_if.sv
// Sequencer-facing handshake and open-drain pad signals of the I2C write engine.
// The engine takes the master modport; the sequencer/pad side takes slave.
`timescale 1ns/1ps

interface i2c_write_engine_if;
    logic       start;
    logic [6:0] addr;
    logic [7:0] wr_data;
    logic       wr_last;
    logic       wr_valid;
    logic       wr_ready;
    logic       sda_in;
    logic       scl_oe;
    logic       sda_oe;
    logic       busy;
    logic       done;
    logic       nack;

    modport master (
        input  start,
        input  addr,
        input  wr_data,
        input  wr_last,
        input  wr_valid,
        input  sda_in,
        output wr_ready,
        output scl_oe,
        output sda_oe,
        output busy,
        output done,
        output nack
    );

    modport slave (
        output start,
        output addr,
        output wr_data,
        output wr_last,
        output wr_valid,
        output sda_in,
        input  wr_ready,
        input  scl_oe,
        input  sda_oe,
        input  busy,
        input  done,
        input  nack
    );
endinterface

// File: rtl/i2c_write_engine.sv
// Write-only I2C master: START, address+W, data bytes with ACK checks, STOP.
// Each bit period is split into four quarters of CLK_DIV clocks.
`timescale 1ns/1ps

module i2c_write_engine #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic                 clock,
    input  logic                 reset_L,
    i2c_write_engine_if.master   bus
);

    localparam int unsigned CntW = $clog2(CLK_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StAddr,
        StData,
        StAck,
        StLoad,
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] qcnt_q, qcnt_d;
    logic [1:0]      quarter_q, quarter_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      sreg_q, sreg_d;
    logic            last_q, last_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            nack_q, nack_d;

    logic            tick;
    logic            phase_end;
    logic            scl_oe;
    logic            sda_oe;
    logic            wr_ready;

    assign tick      = (qcnt_q == CntMax);
    assign phase_end = tick && (quarter_q == 2'd3);

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            state_q   <= StIdle;
            qcnt_q    <= '0;
            quarter_q <= '0;
            bit_cnt_q <= '0;
            sreg_q    <= '0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            nack_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            quarter_q <= quarter_d;
            bit_cnt_q <= bit_cnt_d;
            sreg_q    <= sreg_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            nack_q    <= nack_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sreg_d    = sreg_q;
        last_d    = last_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        nack_d    = nack_q;
        scl_oe    = 1'b0;
        sda_oe    = 1'b0;
        wr_ready  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    sreg_d    = {bus.addr, 1'b0};
                    bit_cnt_d = '0;
                    last_d    = 1'b0;
                    nack_d    = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = StStart;
                end
            end

            StStart: begin
                // SDA falls in the second half while SCL stays high.
                sda_oe = quarter_q[1];
                if (phase_end) begin
                    state_d = StAddr;
                end
            end

            StAddr, StData: begin
                scl_oe = ~quarter_q[1];
                sda_oe = ~sreg_q[7];
                if (phase_end) begin
                    sreg_d    = {sreg_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StAck;
                    end
                end
            end

            StAck: begin
                scl_oe = ~quarter_q[1];
                if (tick && (quarter_q == 2'd2) && bus.sda_in) begin
                    nack_d = 1'b1;
                end
                // last_q is clear during the address byte, so it only ends data frames.
                if (phase_end) begin
                    state_d = (nack_q || last_q) ? StStop : StLoad;
                end
            end

            StLoad: begin
                scl_oe   = 1'b1;
                wr_ready = 1'b1;
                if (bus.wr_valid) begin
                    sreg_d  = bus.wr_data;
                    last_d  = bus.wr_last;
                    state_d = StData;
                end
            end

            StStop: begin
                scl_oe = (quarter_q == 2'd0);
                sda_oe = ~quarter_q[1];
                if (phase_end) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Quarter timing restarts from zero whenever the state changes.
    always_comb begin
        qcnt_d    = qcnt_q;
        quarter_d = quarter_q;
        if ((state_d != state_q) || (state_q == StIdle)) begin
            qcnt_d    = '0;
            quarter_d = '0;
        end else if (tick) begin
            qcnt_d    = '0;
            quarter_d = quarter_q + 2'd1;
        end else begin
            qcnt_d    = qcnt_q + CntW'(1);
        end
    end

    assign bus.scl_oe   = scl_oe;
    assign bus.sda_oe   = sda_oe;
    assign bus.wr_ready = wr_ready;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.nack     = nack_q;

endmodule
